psram_arbiter: RTL and testbench
================================

# psram_arbiter

Shares the single PSRAM controller port between the framebuffer write path (SPI-fed pixel bursts) and the HDMI scan-out read path (line fetch). It sits in the PSRAM clock domain between `framebuffer_writer`/the line fetcher and the PSRAM controller. It grants whole 8-beat bursts, gives the reader priority so scan-out never underflows, and optionally guards the writer against starvation.

## Interface
- `BURST_LEN`, 8: beats per burst, 64-bit each.
- `ADDR_W`, 21: PSRAM word address width.
- `STARVE_LIMIT`, 4: consecutive reader wins tolerated while the writer is pending; used only with the guard compiled in.
- `i_clk` in 1: PSRAM clock, the only clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_w_req` in 1: writer burst request; level.
- `i_w_addr` in ADDR_W: writer burst start address; stable while `i_w_req`=1.
- `i_w_data` in 64: writer beat data.
- `i_w_mask` in 8: writer byte mask; 1 means the byte is masked.
- `o_w_gnt` out 1: one-cycle writer grant pulse.
- `i_r_req` in 1: reader burst request; level.
- `i_r_addr` in ADDR_W: reader burst start address.
- `o_r_gnt` out 1: one-cycle reader grant pulse.
- `o_r_data` out 64: read beat data.
- `o_r_valid` out 1: read beat strobe.
- `o_cmd_en` out 1: command strobe to the controller.
- `o_cmd_wr` out 1: 1 = write, 0 = read.
- `o_addr` out ADDR_W: command address.
- `o_wr_data` out 64: write beat data to the controller.
- `o_wr_mask` out 8: write mask to the controller.
- `i_ctrl_busy` in 1: controller cannot accept a command.
- `i_rd_data` in 64: controller read data.
- `i_rd_valid` in 1: controller read beat strobe.

## Operation
- States: IDLE, W_CMD, W_DATA, R_CMD, R_DATA.
- **IDLE**
  - Nothing is issued while `i_ctrl_busy`=1.
  - Otherwise:
    - If only `i_r_req` is high, go to R_CMD.
    - If only `i_w_req` is high, go to W_CMD.
    - If both are high, the reader wins. The exception is the guard below.
  - A request deasserted in IDLE before its grant is simply dropped.
- **W_CMD** (1 cycle)
  - Asserts `o_cmd_en`=1, `o_cmd_wr`=1, `o_addr`=`i_w_addr`, `o_w_gnt`=1.
  - Then goes to W_DATA.
- **W_DATA** (BURST_LEN cycles)
  - `o_wr_data`/`o_wr_mask` follow `i_w_data`/`i_w_mask` combinationally.
  - The beat counter runs 0..BURST_LEN-1, then the state returns to IDLE.
- **R_CMD** (1 cycle)
  - Asserts `o_cmd_en`=1, `o_cmd_wr`=0, `o_addr`=`i_r_addr`, `o_r_gnt`=1.
  - Then goes to R_DATA.
- **R_DATA**
  - Each `i_rd_valid` beat is registered to `o_r_data`/`o_r_valid` and counted.
  - After BURST_LEN beats the state returns to IDLE.
  - There is no timeout; the controller guarantees the beats arrive.
- A granted burst always completes. Request changes during a burst are ignored.
- The beat counter is `$clog2(BURST_LEN)` bits wide and wraps to 0 at burst end.
- Outputs outside the active states:
  - `o_cmd_en`, `o_w_gnt`, `o_r_gnt` and `o_r_valid` are 0.
  - `o_wr_mask` is 8'hFF (all bytes masked).
  - `o_wr_data` is 0.

## Timing
- Request to grant takes 1 cycle: the request is sampled in IDLE, and the grant and command appear the next cycle.
- Writer beat 0 is presented on the cycle after `o_w_gnt` and then on each following edge for BURST_LEN cycles.
- Read data latency is 1 cycle from `i_rd_valid` to `o_r_valid`.
- Minimum back-to-back burst spacing:
  - Write: 1 + BURST_LEN + 1 cycles (IDLE included).
  - Read: 1 + data time + 1 cycles.
- Reset, including mid-burst:
  - The state returns to IDLE and the counters clear.
  - All outputs take their idle values on the same reset assertion.
  - A partial burst is abandoned; requesters must re-request after reset.

## Configuration
- `PSRAM_ARB_STARVE_GUARD_EN` defined:
  - A starvation counter increments on each reader grant made while `i_w_req`=1.
  - When the count reaches STARVE_LIMIT, the writer wins the next tie.
  - The counter clears on any writer grant and on reset.
- `PSRAM_ARB_STARVE_GUARD_EN` undefined: the reader always wins ties, and no counter is built.

## Structure
- Package `psram_arb_pkg` holds:
  - the state enum `psram_arb_state_t`;
  - `PSRAM_BURST_LEN`=8;
  - `PSRAM_ADDR_W`=21;
  - `PSRAM_MASK_ALL`=8'hFF.
- One sub-module, `psram_arb_starve_cnt`: a saturating counter with clear and a limit flag. It is instantiated only under the macro.

## Test plan
- **Writer only:** `i_w_req`=1, addr 0x00123. Expect `o_w_gnt` and `o_cmd_en` with `o_cmd_wr`=1 and `o_addr`=0x00123 one cycle later, then 8 data beats passed through with masks, then return to IDLE.
- **Reader only:** `i_r_req`=1, addr 0x1F000, controller returns 8 beats 0..7. Expect `o_r_valid` ×8 with data 0..7, each 1 cycle after the matching `i_rd_valid`.
- **Simultaneous requests:** both requests high in IDLE. Expect the read burst first, then the write burst.
- **Starvation guard (macro on):** reader held high, writer high. Expect 4 read bursts, then 1 write burst. With the macro off, expect no write burst.
- **Busy hold:** `i_ctrl_busy`=1 for 10 cycles with `i_w_req`=1. Expect no grant until busy falls, then a grant 1 cycle later.
- **Mid-burst reset:** assert `i_rst` during W_DATA beat 3. Expect all outputs at idle values immediately. After release with `i_w_req`=1, expect a fresh grant with the beat count restarting at 0.

Source files
------------

// File: rtl/psram_arb_pkg.sv
// Shared types and constants for the PSRAM port arbiter.
package psram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_CMD,
    W_DATA,
    R_CMD,
    R_DATA
  } psram_arb_state_t;

  localparam int unsigned PSRAM_BURST_LEN = 8;
  localparam int unsigned PSRAM_ADDR_W    = 21;
  localparam logic [7:0]  PSRAM_MASK_ALL  = 8'hFF;

endpackage

// File: rtl/psram_arb_starve_cnt.sv
// Saturating starvation counter with synchronous clear and a limit flag.
module psram_arb_starve_cnt #(
  parameter int unsigned LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_limit
);

  localparam int unsigned CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear wins over increment; the count sticks at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && (cnt_q < LIMIT_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_limit = (cnt_q >= LIMIT_V);

endmodule

// File: rtl/psram_arbiter.sv
// Arbitrates the single PSRAM controller port between the framebuffer writer
// and the scan-out line reader. Whole bursts are granted; the reader wins ties.
// Define PSRAM_ARB_STARVE_GUARD_EN to let a pending writer win a tie after
// STARVE_LIMIT reader grants made while it was waiting.
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int unsigned BURST_LEN    = PSRAM_BURST_LEN,
  parameter int unsigned ADDR_W       = PSRAM_ADDR_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_w_req,
  input  logic [ADDR_W-1:0] i_w_addr,
  input  logic [63:0]       i_w_data,
  input  logic [7:0]        i_w_mask,
  output logic              o_w_gnt,
  input  logic              i_r_req,
  input  logic [ADDR_W-1:0] i_r_addr,
  output logic              o_r_gnt,
  output logic [63:0]       o_r_data,
  output logic              o_r_valid,
  output logic              o_cmd_en,
  output logic              o_cmd_wr,
  output logic [ADDR_W-1:0] o_addr,
  output logic [63:0]       o_wr_data,
  output logic [7:0]        o_wr_mask,
  input  logic              i_ctrl_busy,
  input  logic [63:0]       i_rd_data,
  input  logic              i_rd_valid
);

  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  if ((BURST_LEN == 0) || (STARVE_LIMIT == 0)) begin : g_bad_cfg
    $error("psram_arbiter: BURST_LEN and STARVE_LIMIT must both be at least 1");
  end

  psram_arb_state_t  state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [63:0]       r_data_q, r_data_d;
  logic              r_valid_q, r_valid_d;
  logic              w_wins_tie;

`ifdef PSRAM_ARB_STARVE_GUARD_EN
  psram_arb_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   ((state_q == R_CMD) && i_w_req),
    .i_clr   (state_q == W_CMD),
    .o_limit (w_wins_tie)
  );
`else
  assign w_wins_tie = 1'b0;
`endif

  // Next-state, beat counting and command/write-path outputs.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    o_cmd_en  = 1'b0;
    o_cmd_wr  = 1'b0;
    o_addr    = '0;
    o_w_gnt   = 1'b0;
    o_r_gnt   = 1'b0;
    o_wr_data = '0;
    o_wr_mask = PSRAM_MASK_ALL;
    case (state_q)
      IDLE: begin
        if (!i_ctrl_busy) begin
          if (i_r_req && (!i_w_req || !w_wins_tie)) begin
            state_d = R_CMD;
          end else if (i_w_req) begin
            state_d = W_CMD;
          end
        end
      end
      W_CMD: begin
        o_cmd_en = 1'b1;
        o_cmd_wr = 1'b1;
        o_addr   = i_w_addr;
        o_w_gnt  = 1'b1;
        beat_d   = '0;
        state_d  = W_DATA;
      end
      W_DATA: begin
        o_wr_data = i_w_data;
        o_wr_mask = i_w_mask;
        beat_d    = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = IDLE;
        end
      end
      R_CMD: begin
        o_cmd_en = 1'b1;
        o_cmd_wr = 1'b0;
        o_addr   = i_r_addr;
        o_r_gnt  = 1'b1;
        beat_d   = '0;
        state_d  = R_DATA;
      end
      R_DATA: begin
        if (i_rd_valid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read beat capture; the last beat's strobe lands in the IDLE cycle that
  // follows R_DATA because of this register stage.
  always_comb begin
    r_valid_d = (state_q == R_DATA) && i_rd_valid;
    r_data_d  = r_valid_d ? i_rd_data : r_data_q;
  end

  // State, beat counter and read output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
    end
  end

  assign o_r_data  = r_data_q;
  assign o_r_valid = r_valid_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Scoreboard bench for psram_arbiter: stimulus pushes expected commands and
// beats, a monitor pops and compares whenever the DUT presents them.
module tb_psram_arbiter;
  import psram_arb_pkg::*;

  localparam int unsigned AW    = PSRAM_ADDR_W;
  localparam int unsigned BL    = PSRAM_BURST_LEN;
  localparam int unsigned LIMIT = 4;
`ifdef PSRAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_w_req;
  logic [AW-1:0] i_w_addr;
  logic [63:0]   i_w_data;
  logic [7:0]    i_w_mask;
  logic          o_w_gnt;
  logic          i_r_req;
  logic [AW-1:0] i_r_addr;
  logic          o_r_gnt;
  logic [63:0]   o_r_data;
  logic          o_r_valid;
  logic          o_cmd_en;
  logic          o_cmd_wr;
  logic [AW-1:0] o_addr;
  logic [63:0]   o_wr_data;
  logic [7:0]    o_wr_mask;
  logic          i_ctrl_busy;
  logic [63:0]   i_rd_data;
  logic          i_rd_valid;

  psram_arbiter #(
    .BURST_LEN(BL),
    .ADDR_W(AW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_w_req(i_w_req), .i_w_addr(i_w_addr), .i_w_data(i_w_data), .i_w_mask(i_w_mask),
    .o_w_gnt(o_w_gnt),
    .i_r_req(i_r_req), .i_r_addr(i_r_addr), .o_r_gnt(o_r_gnt),
    .o_r_data(o_r_data), .o_r_valid(o_r_valid),
    .o_cmd_en(o_cmd_en), .o_cmd_wr(o_cmd_wr), .o_addr(o_addr),
    .o_wr_data(o_wr_data), .o_wr_mask(o_wr_mask),
    .i_ctrl_busy(i_ctrl_busy), .i_rd_data(i_rd_data), .i_rd_valid(i_rd_valid)
  );

  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct packed { logic wr; logic [AW-1:0] addr; } cmd_t;
  typedef struct packed { logic [63:0] data; logic [7:0] mask; } wbeat_t;
  typedef struct packed { logic [63:0] data; logic [31:0] cyc; } rbeat_t;

  cmd_t   cmd_q[$];
  wbeat_t wb_q[$];
  rbeat_t rb_q[$];

  int unsigned starve = 0;   // reference model: reader wins seen by a waiting writer
  bit          rd_seq = 1'b0;
  bit          rd_busy = 1'b0;
  int unsigned wwin = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no response within bound (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_writer_wins_tie();
    return GUARD && (starve >= LIMIT);
  endfunction

  function automatic void push_w(input logic [AW-1:0] a);
    cmd_q.push_back({1'b1, a});
    starve = 0;
  endfunction

  function automatic void push_r(input logic [AW-1:0] a, input bit w_waiting);
    cmd_q.push_back({1'b0, a});
    if (w_waiting && starve < LIMIT) starve++;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge i_clk) begin
    cmd_t   c;
    wbeat_t wb;
    rbeat_t rb;
    if (i_rst) begin
      wwin = 0;
    end else begin
      if (wwin > 1) begin
        if (wb_q.size() == 0) timeout_fail("wr_beat_unexpected");
        else begin
          wb = wb_q.pop_front();
          check("wr_data", o_wr_data, wb.data);
          check("wr_mask", {56'd0, o_wr_mask}, {56'd0, wb.mask});
        end
        wwin--;
      end else if (wwin == 1) begin
        check("idle_wr_data", o_wr_data, 64'd0);
        check("idle_wr_mask", {56'd0, o_wr_mask}, 64'hFF);
        check("idle_cmd_en", {63'd0, o_cmd_en}, 64'd0);
        wwin = 0;
      end
      if (o_cmd_en === 1'b1) begin
        if (cmd_q.size() == 0) timeout_fail("cmd_unexpected");
        else begin
          c = cmd_q.pop_front();
          check("cmd_wr", {63'd0, o_cmd_wr}, {63'd0, c.wr});
          check("cmd_addr", {43'd0, o_addr}, {43'd0, c.addr});
          check("w_gnt", {63'd0, o_w_gnt}, {63'd0, c.wr});
          check("r_gnt", {63'd0, o_r_gnt}, {63'd0, ~c.wr});
        end
        if (o_w_gnt === 1'b1) wwin = BL + 1;
      end
      if (o_r_valid === 1'b1) begin
        if (rb_q.size() == 0) timeout_fail("rd_beat_unexpected");
        else begin
          rb = rb_q.pop_front();
          check("rd_data", o_r_data, rb.data);
          check("rd_latency", {32'd0, cyc}, {32'd0, rb.cyc});
        end
      end
    end
  end

  // ---------------- controller read emulation ----------------
  initial begin
    logic [63:0] d;
    i_rd_valid = 1'b0;
    i_rd_data  = '0;
    forever begin
      @(negedge i_clk);
      if (!i_rst && o_cmd_en === 1'b1 && o_cmd_wr === 1'b0) begin
        rd_busy = 1'b1;
        for (int b = 0; b < BL; b++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge i_clk); #1;
            i_rd_valid = 1'b0;
            i_rd_data  = {$urandom, $urandom};
          end
          @(posedge i_clk); #1;
          d = rd_seq ? 64'(b) : {$urandom, $urandom};
          i_rd_valid = 1'b1;
          i_rd_data  = d;
          rb_q.push_back({d, 32'(cyc + 1)});
        end
        @(posedge i_clk); #1;
        i_rd_valid = 1'b0;
        rd_busy = 1'b0;
      end
    end
  end

  // ---------------- requester tasks ----------------
  task automatic writer_serve(input int abort_beat, output int unsigned gcyc);
    int n = 0;
    wbeat_t wb;
    gcyc = 0;
    do begin @(negedge i_clk); n++; end while (o_w_gnt !== 1'b1 && n < 3000);
    if (o_w_gnt !== 1'b1) begin
      timeout_fail("w_gnt_timeout");
      i_w_req = 1'b0;
      return;
    end
    gcyc = cyc;
    i_w_req = 1'b0;
    for (int b = 0; b < BL; b++) begin
      @(posedge i_clk); #1;
      if (b == abort_beat) begin
        i_rst = 1'b1;
        #1;
        check("rst_cmd_en",  {63'd0, o_cmd_en},  64'd0);
        check("rst_w_gnt",   {63'd0, o_w_gnt},   64'd0);
        check("rst_r_gnt",   {63'd0, o_r_gnt},   64'd0);
        check("rst_r_valid", {63'd0, o_r_valid}, 64'd0);
        check("rst_wr_mask", {56'd0, o_wr_mask}, 64'hFF);
        check("rst_wr_data", o_wr_data, 64'd0);
        wb_q.delete();
        return;
      end
      wb.data = {$urandom, $urandom};
      wb.mask = 8'($urandom);
      i_w_data = wb.data;
      i_w_mask = wb.mask;
      wb_q.push_back(wb);
    end
    @(posedge i_clk); #1;
    i_w_data = {$urandom, $urandom};
    i_w_mask = 8'($urandom);
  endtask

  task automatic reader_serve(output int unsigned gcyc);
    int n = 0;
    gcyc = 0;
    do begin @(negedge i_clk); n++; end while (o_r_gnt !== 1'b1 && n < 3000);
    if (o_r_gnt !== 1'b1) begin
      timeout_fail("r_gnt_timeout");
      i_r_req = 1'b0;
      return;
    end
    gcyc = cyc;
    i_r_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((cmd_q.size() != 0 || wb_q.size() != 0 || rb_q.size() != 0 ||
            wwin != 0 || rd_busy) && n < 3000) begin
      @(posedge i_clk); n++;
    end
    if (n >= 3000) timeout_fail("idle_timeout");
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  // One writer and/or reader burst, optionally behind a busy window.
  task automatic pair(input bit do_w, input bit do_r, input logic [AW-1:0] wa,
                      input logic [AW-1:0] ra, input int unsigned k);
    int unsigned gw, gr;
    if (do_w && do_r) begin
      if (model_writer_wins_tie()) begin push_w(wa); push_r(ra, 1'b0); end
      else begin push_r(ra, 1'b1); push_w(wa); end
    end else if (do_w) push_w(wa);
    else if (do_r) push_r(ra, 1'b0);
    i_ctrl_busy = (k > 0);
    if (do_w) begin i_w_req = 1'b1; i_w_addr = wa; end
    if (do_r) begin i_r_req = 1'b1; i_r_addr = ra; end
    fork
      begin if (do_w) writer_serve(-1, gw); end
      begin if (do_r) reader_serve(gr); end
      begin repeat (k) @(posedge i_clk); #1; i_ctrl_busy = 1'b0; end
    join
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned rc, gc, gw, bc;
    int g, n;
    bit wdone;
    i_rst = 1'b1; i_w_req = 1'b0; i_r_req = 1'b0; i_ctrl_busy = 1'b0;
    i_w_addr = '0; i_r_addr = '0; i_w_data = '0; i_w_mask = '0;
    repeat (3) @(negedge i_clk);
    check("reset_cmd_en",  {63'd0, o_cmd_en},  64'd0);
    check("reset_w_gnt",   {63'd0, o_w_gnt},   64'd0);
    check("reset_r_gnt",   {63'd0, o_r_gnt},   64'd0);
    check("reset_r_valid", {63'd0, o_r_valid}, 64'd0);
    check("reset_wr_mask", {56'd0, o_wr_mask}, 64'hFF);
    check("reset_wr_data", o_wr_data, 64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk); #1;

    // Writer only: grant exactly one cycle after the request is raised.
    push_w(21'h00123);
    rc = cyc; i_w_req = 1'b1; i_w_addr = 21'h00123;
    writer_serve(-1, gc);
    check("w_req_to_gnt", 64'(gc), 64'(rc + 1));
    wait_idle();

    // Reader only, controller returns 0..7.
    rd_seq = 1'b1;
    push_r(21'h1F000, 1'b0);
    rc = cyc; i_r_req = 1'b1; i_r_addr = 21'h1F000;
    reader_serve(gc);
    check("r_req_to_gnt", 64'(gc), 64'(rc + 1));
    wait_idle();
    rd_seq = 1'b0;

    // Simultaneous requests.
    pair(1'b1, 1'b1, 21'h0ABCD, 21'h15555, 0);

    // Busy hold for 10 cycles, grant one cycle after busy falls.
    push_w(21'h0BEEF);
    i_ctrl_busy = 1'b1; i_w_req = 1'b1; i_w_addr = 21'h0BEEF;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      check("busy_no_cmd", {63'd0, o_cmd_en}, 64'd0);
    end
    @(posedge i_clk); #1;
    i_ctrl_busy = 1'b0; bc = cyc;
    writer_serve(-1, gc);
    check("busy_release_gnt", 64'(gc), 64'(bc + 1));
    wait_idle();

    // Starvation: reader held, writer pending; stop the reader after 5 grants.
    wdone = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (!wdone && model_writer_wins_tie()) begin push_w(21'h01111); wdone = 1'b1; end
      else push_r(21'h02222, !wdone);
    end
    if (!wdone) push_w(21'h01111);
    i_w_req = 1'b1; i_w_addr = 21'h01111;
    i_r_req = 1'b1; i_r_addr = 21'h02222;
    fork
      writer_serve(-1, gw);
      begin
        g = 0; n = 0;
        while (g < 5 && n < 3000) begin
          @(negedge i_clk); n++;
          if (o_cmd_en === 1'b1) g++;
        end
        i_r_req = 1'b0;
        if (g < 5) timeout_fail("starve_grants");
      end
    join
    wait_idle();

    // Reset during write beat 3, then a fresh full burst.
    push_w(21'h00777);
    i_w_req = 1'b1; i_w_addr = 21'h00777;
    writer_serve(3, gc);
    cmd_q.delete();
    starve = 0;
    repeat (2) @(posedge i_clk); #1;
    i_rst = 1'b0;
    push_w(21'h00778);
    rc = cyc; i_w_req = 1'b1; i_w_addr = 21'h00778;
    writer_serve(-1, gc);
    check("post_reset_gnt", 64'(gc), 64'(rc + 1));
    wait_idle();

    // Randomized mix.
    for (int i = 0; i < 25; i++) begin
      int unsigned p;
      p = $urandom_range(0, 2);
      pair(p != 1, p != 0, AW'($urandom), AW'($urandom), $urandom_range(0, 3));
    end

    check("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
    check("rb_q_drained",  64'(rb_q.size()),  64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
